// File: rtl/result_reader_pkg.sv
// Shared constants and state encoding for the privacy-amplification result path.
package result_reader_pkg;

  localparam int RESULT_W = 3072;
  localparam int WORD_W   = 32;
  localparam int NWORDS   = RESULT_W / WORD_W;
  localparam int IDX_W    = $clog2(NWORDS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/result_reader_if.sv
// Word stream from the result reader to the downstream sink (valid/ready with last flag).
interface result_reader_if #(
  parameter int WORD_W = result_reader_pkg::WORD_W
);
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/result_word_mux.sv
// Selects one output word from the held result block; kept separate so the wide mux can be timed on its own.
module result_word_mux #(
  parameter int RESULT_W = result_reader_pkg::RESULT_W,
  parameter int WORD_W   = result_reader_pkg::WORD_W,
  parameter int IDX_W    = result_reader_pkg::IDX_W
) (
  input  logic [RESULT_W-1:0] hold_i,
  input  logic [IDX_W-1:0]    idx_i,
  output logic [WORD_W-1:0]   word_o
);

  assign word_o = hold_i[idx_i*WORD_W +: WORD_W];

endmodule

// File: rtl/result_reader.sv
// Captures each result block on fifo_write and streams it out LSB-word-first over valid/ready.
//
// state | meaning
// IDLE  | no block held, waiting for fifo_write
// SEND  | block held, presenting word idx to the sink
module result_reader
  import result_reader_pkg::*;
#(
  parameter int RESULT_W = result_reader_pkg::RESULT_W,
  parameter int WORD_W   = result_reader_pkg::WORD_W,
  parameter int CNT_W    = 16
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [RESULT_W-1:0] result,
  input  logic                fifo_write,
  result_reader_if.master     out_if,
  output logic                busy,
  output logic                overflow,
  output logic [CNT_W-1:0]    block_count
);

  localparam int NW    = RESULT_W / WORD_W;
  localparam int IW    = $clog2(NW);

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [RESULT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [WORD_W-1:0]   word;
  logic                last_word;
  logic                handshake;

  assign last_word = (idx_q == IW'(NW - 1));
  assign handshake = (state_q == SEND) && out_if.out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (fifo_write) begin
          hold_d  = result;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (handshake && last_word) begin
          cnt_d = cnt_q + CNT_W'(1);
          idx_d = '0;
          // A block arriving exactly as the last word leaves is accepted, not dropped.
          if (fifo_write) hold_d = result;
          else            state_d = IDLE;
        end else begin
          if (handshake)  idx_d = idx_q + IW'(1);
          if (fifo_write) ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  result_word_mux #(
    .RESULT_W (RESULT_W),
    .WORD_W   (WORD_W),
    .IDX_W    (IW)
  ) u_word_mux (
    .hold_i (hold_q),
    .idx_i  (idx_q),
    .word_o (word)
  );

  // Data is forced to zero outside SEND so stale block contents never leak.
  assign out_if.out_data  = (state_q == SEND) ? word : '0;
  assign out_if.out_valid = (state_q == SEND);
  assign out_if.out_last  = (state_q == SEND) && last_word;
  assign busy             = (state_q == SEND);
  assign overflow         = ovf_q;
  assign block_count      = cnt_q;

endmodule
